// File: rtl/nn_pio_pkg.sv
// rtl/nn_pio_pkg.sv - shared opcodes, PIO field positions, FSM states and Q8.8 limits
package nn_pio_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_LD_W  = 3'd2;
    localparam logic [2:0] OP_LD_X  = 3'd3;
    localparam logic [2:0] OP_RUN   = 3'd4;
    localparam logic [2:0] OP_RD    = 3'd5;

    localparam int CMD_REQ_BIT  = 31;
    localparam int CMD_OP_LSB   = 28;
    localparam int CMD_IDX_LSB  = 24;
    localparam int CMD_RELU_BIT = 21;
    localparam int CMD_LEN_LSB  = 16;

    localparam int RSP_ACK_BIT  = 31;
    localparam int RSP_BUSY_BIT = 30;
    localparam int RSP_ERR_BIT  = 29;
    localparam int RSP_SAT_BIT  = 28;

    localparam logic [15:0] QMAX = 16'h7FFF;
    localparam logic [15:0] QMIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MAC,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/nn_mac_unit.sv
// rtl/nn_mac_unit.sv - signed multiply-accumulate with Q8.8 shift, optional ReLU and saturation
module nn_mac_unit
    import nn_pio_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     relu,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic [DATA_W-1:0]        res,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-16){1'b0}}, QMAX};
    localparam logic signed [ACC_W-1:0] R_MIN = {{(ACC_W-16){1'b1}}, QMIN};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    shifted;

    assign prod    = a * b;
    assign shifted = acc >>> FRAC_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    // ReLU is applied before clipping so a negative result never reports sat.
    always_comb begin
        res = shifted[DATA_W-1:0];
        sat = 1'b0;
        if (relu && shifted[ACC_W-1]) begin
            res = '0;
        end else if (shifted > R_MAX) begin
            res = QMAX;
            sat = 1'b1;
        end else if (shifted < R_MIN) begin
            res = QMIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/nn_pio_cmd_engine.sv
// rtl/nn_pio_cmd_engine.sv - toggle-handshake PIO command engine around a dot-product MAC
module nn_pio_cmd_engine
    import nn_pio_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] hps_cmd,
    output logic [31:0] fpga_rsp,
    output logic        busy,
    output logic        result_valid
);

    state_t state_q, state_d;

    logic [31:0]       cmd_q;
    logic [31:0]       cmd_l;
    logic              ack_tgl;
    logic              err_q;
    logic              sat_q;
    logic [DATA_W-1:0] data_q;
    logic              rv_q;
    logic [3:0]        mac_i;
    logic [DATA_W-1:0] w_mem [DEPTH];
    logic [DATA_W-1:0] x_mem [DEPTH];

    logic [2:0]        cmd_op;
    logic [3:0]        cmd_idx;
    logic [4:0]        cmd_len;
    logic              cmd_relu;
    logic [DATA_W-1:0] cmd_val;
    logic              cmd_ok;
    logic              new_req;
    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] mac_res;
    logic              mac_sat;
    logic              unused_ok;

    assign cmd_op    = cmd_l[CMD_OP_LSB +: 3];
    assign cmd_idx   = cmd_l[CMD_IDX_LSB +: 4];
    assign cmd_len   = cmd_l[CMD_LEN_LSB +: 5];
    assign cmd_relu  = cmd_l[CMD_RELU_BIT];
    assign cmd_val   = cmd_l[DATA_W-1:0];
    assign unused_ok = &{1'b0, cmd_l[23:22]};

    assign new_req = cmd_q[CMD_REQ_BIT] != ack_tgl;

    always_comb begin
        cmd_ok = 1'b0;
        case (cmd_op)
            OP_NOP, OP_CLEAR, OP_RD: cmd_ok = 1'b1;
            OP_LD_W, OP_LD_X:        cmd_ok = 32'(cmd_idx) < DEPTH;
            OP_RUN:                  cmd_ok = (cmd_len != 5'd0) && (32'(cmd_len) <= DEPTH);
            default:                 cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_req) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cmd_op == OP_RUN && cmd_ok) begin
                    state_d = ST_MAC;
                    mac_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    mac_clr = (cmd_op == OP_CLEAR);
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if ({1'b0, mac_i} == cmd_len - 5'd1) state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_q   <= '0;
            cmd_l   <= '0;
            ack_tgl <= 1'b0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            rv_q    <= 1'b0;
            mac_i   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                w_mem[k] <= '0;
                x_mem[k] <= '0;
            end
        end else begin
            cmd_q <= hps_cmd;
            case (state_q)
                ST_IDLE: begin
                    if (new_req) cmd_l <= cmd_q;
                end
                ST_EXEC: begin
                    if (cmd_op == OP_RUN && cmd_ok) begin
                        mac_i <= '0;
                        rv_q  <= 1'b0;
                    end else begin
                        ack_tgl <= ~ack_tgl;
                        err_q   <= ~cmd_ok;
                        if (cmd_ok) begin
                            case (cmd_op)
                                OP_CLEAR: begin
                                    for (int k = 0; k < DEPTH; k++) begin
                                        w_mem[k] <= '0;
                                        x_mem[k] <= '0;
                                    end
                                    data_q <= '0;
                                    sat_q  <= 1'b0;
                                    rv_q   <= 1'b0;
                                end
                                OP_LD_W: begin
                                    w_mem[cmd_idx] <= cmd_val;
                                    data_q         <= cmd_val;
                                    rv_q           <= 1'b0;
                                end
                                OP_LD_X: begin
                                    x_mem[cmd_idx] <= cmd_val;
                                    data_q         <= cmd_val;
                                    rv_q           <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_MAC: mac_i <= mac_i + 4'd1;
                ST_FINISH: begin
                    data_q  <= mac_res;
                    sat_q   <= mac_sat;
                    rv_q    <= 1'b1;
                    err_q   <= 1'b0;
                    ack_tgl <= ~ack_tgl;
                end
                default: ;
            endcase
        end
    end

    nn_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .relu  (cmd_relu),
        .a     (w_mem[mac_i]),
        .b     (x_mem[mac_i]),
        .res   (mac_res),
        .sat   (mac_sat)
    );

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = rv_q;

    always_comb begin
        fpga_rsp               = '0;
        fpga_rsp[RSP_ACK_BIT]  = ack_tgl;
        fpga_rsp[RSP_BUSY_BIT] = busy;
        fpga_rsp[RSP_ERR_BIT]  = err_q;
        fpga_rsp[RSP_SAT_BIT]  = sat_q;
        fpga_rsp[DATA_W-1:0]   = data_q;
    end

endmodule

// File: tb/tb_nn_pio_cmd_engine.sv
// tb/tb_nn_pio_cmd_engine.sv - table-driven bench for the PIO command engine
module tb_nn_pio_cmd_engine;
    import nn_pio_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] hps_cmd;
    logic [31:0] fpga_rsp;
    logic        busy;
    logic        result_valid;

    int checks;
    int errors;
    logic tgl;

    nn_pio_cmd_engine dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .hps_cmd       (hps_cmd),
        .fpga_rsp      (fpga_rsp),
        .busy          (busy),
        .result_valid  (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  idx;
        logic [4:0]  len;
        logic        relu;
        logic [15:0] val;
        logic        e_err;
        logic [15:0] e_data;
        logic        e_sat;
        logic        e_rv;
        int          e_lat;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] idx, input logic [4:0] len,
                          input logic relu, input logic [15:0] val, output int lat);
        tgl = ~tgl;
        @(negedge clk);
        hps_cmd = {tgl, op, idx, 2'b00, relu, len, val};
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (fpga_rsp[31] == tgl) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int n_wait;
        checks  = 0;
        errors  = 0;
        tgl     = 1'b0;
        hps_cmd = '0;
        rst_n   = 1'b0;

        vecs[0]  = '{OP_LD_W,  4'd0,  5'd0,  1'b0, 16'h0180, 1'b0, 16'h0180, 1'b0, 1'b0, 2};
        vecs[1]  = '{OP_LD_X,  4'd0,  5'd0,  1'b0, 16'h0200, 1'b0, 16'h0200, 1'b0, 1'b0, 2};
        vecs[2]  = '{OP_LD_W,  4'd1,  5'd0,  1'b0, 16'hFF00, 1'b0, 16'hFF00, 1'b0, 1'b0, 2};
        vecs[3]  = '{OP_LD_X,  4'd1,  5'd0,  1'b0, 16'h0080, 1'b0, 16'h0080, 1'b0, 1'b0, 2};
        vecs[4]  = '{OP_RUN,   4'd0,  5'd2,  1'b0, 16'h0000, 1'b0, 16'h0280, 1'b0, 1'b1, 5};
        vecs[5]  = '{OP_LD_W,  4'd0,  5'd0,  1'b0, 16'hFE00, 1'b0, 16'hFE00, 1'b0, 1'b0, 2};
        vecs[6]  = '{OP_RUN,   4'd0,  5'd2,  1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 5};
        vecs[7]  = '{OP_RUN,   4'd0,  5'd2,  1'b0, 16'h0000, 1'b0, 16'hFB80, 1'b0, 1'b1, 5};
        vecs[8]  = '{OP_LD_W,  4'd0,  5'd0,  1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0, 2};
        vecs[9]  = '{OP_LD_W,  4'd15, 5'd0,  1'b0, 16'h0100, 1'b0, 16'h0100, 1'b0, 1'b0, 2};
        vecs[10] = '{3'd7,     4'd0,  5'd0,  1'b0, 16'h5555, 1'b1, 16'h0100, 1'b0, 1'b0, 2};
        vecs[11] = '{OP_RUN,   4'd0,  5'd0,  1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 2};
        vecs[12] = '{OP_RUN,   4'd0,  5'd17, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 2};
        vecs[13] = '{OP_RD,    4'd0,  5'd0,  1'b0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b0, 2};
        vecs[14] = '{OP_RUN,   4'd0,  5'd2,  1'b0, 16'h0000, 1'b0, 16'h23E8, 1'b0, 1'b1, 5};
        vecs[15] = '{OP_CLEAR, 4'd0,  5'd0,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 2};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_rsp", fpga_rsp, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_rv", {31'b0, result_valid}, 32'h0);

        for (int v = 0; v < 16; v++) begin
            do_cmd(vecs[v].op, vecs[v].idx, vecs[v].len, vecs[v].relu, vecs[v].val, lat);
            chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].e_lat));
            chk($sformatf("v%0d_err", v), {31'b0, fpga_rsp[29]}, {31'b0, vecs[v].e_err});
            chk($sformatf("v%0d_data", v), {16'h0, fpga_rsp[15:0]}, {16'h0, vecs[v].e_data});
            chk($sformatf("v%0d_sat", v), {31'b0, fpga_rsp[28]}, {31'b0, vecs[v].e_sat});
            chk($sformatf("v%0d_rv", v), {31'b0, result_valid}, {31'b0, vecs[v].e_rv});
            chk($sformatf("v%0d_busy", v), {30'b0, fpga_rsp[30], busy}, 32'h0);
        end

        for (int k = 0; k < 16; k++) begin
            do_cmd(OP_LD_W, 4'(k), 5'd0, 1'b0, 16'h7F00, lat);
            do_cmd(OP_LD_X, 4'(k), 5'd0, 1'b0, 16'h7F00, lat);
        end
        do_cmd(OP_RUN, 4'd0, 5'd16, 1'b0, 16'h0, lat);
        chk("sat_lat", 32'(lat), 32'd19);
        chk("sat_data", {16'h0, fpga_rsp[15:0]}, 32'h7FFF);
        chk("sat_flag", {31'b0, fpga_rsp[28]}, 32'h1);
        chk("sat_rv", {31'b0, result_valid}, 32'h1);
        do_cmd(OP_RD, 4'd0, 5'd0, 1'b0, 16'h0, lat);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", {16'h0, fpga_rsp[15:0]}, 32'h7FFF);
        chk("rd_sat", {31'b0, fpga_rsp[28]}, 32'h1);

        // LD_X requested mid-MAC must wait, then be taken right after the RUN ack
        tgl = ~tgl;
        @(negedge clk);
        hps_cmd = {tgl, OP_RUN, 4'd0, 2'b00, 1'b0, 5'd16, 16'h0};
        repeat (6) @(negedge clk);
        chk("q_busy_mid", {31'b0, busy}, 32'h1);
        tgl = ~tgl;
        hps_cmd = {tgl, OP_LD_X, 4'd3, 2'b00, 1'b0, 5'd0, 16'h0055};
        n_wait = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (fpga_rsp[31] == ~tgl) begin
                n_wait = n;
                break;
            end
        end
        chk("q_run_acked", {31'b0, (n_wait > 0)}, 32'h1);
        chk("q_run_data", {16'h0, fpga_rsp[15:0]}, 32'h7FFF);
        n_wait = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (fpga_rsp[31] == tgl) begin
                n_wait = n;
                break;
            end
        end
        chk("q_ldx_lat", 32'(n_wait), 32'd2);
        chk("q_ldx_data", {16'h0, fpga_rsp[15:0]}, 32'h0055);

        tgl = ~tgl;
        @(negedge clk);
        hps_cmd = {tgl, OP_RUN, 4'd0, 2'b00, 1'b0, 5'd16, 16'h0};
        repeat (6) @(negedge clk);
        chk("r_busy_mid", {31'b0, busy}, 32'h1);
        #2;
        rst_n   = 1'b0;
        hps_cmd = '0;
        tgl     = 1'b0;
        #1;
        chk("r_async_rsp", fpga_rsp, 32'h0);
        chk("r_async_busy", {31'b0, busy}, 32'h0);
        chk("r_async_rv", {31'b0, result_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("r_after_rsp", fpga_rsp, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_pio_cmd_engine.md
Name: nn_pio_cmd_engine

Overview:
- FPGA-side consumer of the HPS command PIO (32-bit HPS output export) and producer of the status/result PIO (32-bit FPGA input export).
- Implements a toggle-handshake command protocol over these strobe-less PIOs.
- Stores neuron weights and inputs, runs a fixed-point dot product with optional ReLU, and returns the saturated result to software.

Parameters:
- DEPTH, 16, number of weight/input entries (max 16; index field is 4 bits).
- DATA_W, 16, signed operand width, Q8.8 format.
- FRAC_W, 8, fractional bits of operands and result.
- ACC_W, 40, signed accumulator width.

Ports:
- clk_clk  in  1  system clock, same clock as the HPS-side PIOs.
- reset_reset_n  in  1  asynchronous, active-low reset.
- hps_cmd  in  32  command word from the HPS output PIO.
- fpga_rsp  out  32  response word to the HPS input PIO.
- busy  out  1  engine not in IDLE.
- result_valid  out  1  high from RUN completion until the next CLEAR, LD_W, LD_X or RUN.

Behaviour:
- Interface (already decided): one clock, clk_clk; reset_reset_n is asynchronous and active-low.
- Command fields:
  - [31] req toggle
  - [30:28] opcode: 0 NOP, 1 CLEAR, 2 LD_W, 3 LD_X, 4 RUN, 5 RD; 6–7 illegal
  - [27:24] index
  - [20:16] RUN length
  - [21] ReLU enable
  - [15:0] signed value
- Response fields:
  - [31] ack toggle
  - [30] busy
  - [29] err
  - [28] sat
  - [27:16] zero
  - [15:0] data
- hps_cmd is registered every cycle (cmd_q). A new request exists when cmd_q[31] != ack_tgl.
- Reset values:
  - fpga_rsp = 0 (ack_tgl = 0)
  - busy = 0
  - result_valid = 0
  - all weight/input registers = 0
  - accumulator = 0
  - FSM in IDLE
- FSM states: IDLE, EXEC, MAC, FINISH.
  - IDLE: on a new request, latch the command and go to EXEC. rsp[30] rises in the same cycle.
  - EXEC (1 cycle): performs NOP/CLEAR/LD_W/LD_X/RD or the error response, toggles ack, clears busy, returns to IDLE. For RUN it clears acc, sets i = 0 and goes to MAC.
  - MAC: acc += w[i]*x[i], one product per cycle, full 32-bit product sign-extended to ACC_W. Runs exactly len cycles, then goes to FINISH.
  - FINISH (1 cycle): computes r = acc >>> FRAC_W (arithmetic). If ReLU is set and r < 0, r = 0. Saturates r to [-32768, 32767], sets sat if clipped, writes data = r, sets result_valid, toggles ack, returns to IDLE.
- Latency from cmd_q showing the new toggle:
  - non-RUN: ack after 2 cycles
  - RUN: ack after len + 3 cycles
- Command semantics:
  - CLEAR zeroes all weights, inputs, acc, data, sat and result_valid.
  - LD_W / LD_X write the value to w[index] / x[index] and echo the value in data.
  - RD returns the last result in data without recomputing.
  - NOP only toggles ack.
- Errors: illegal opcode, index >= DEPTH on LD_W/LD_X, or RUN len == 0 or len > DEPTH.
  - err = 1, no storage change, ack still toggles.
  - err is cleared by the next successful command.
- Requests arriving while busy are not dropped: the toggle mismatch persists and the command is accepted on return to IDLE, using the latest hps_cmd contents.
- A toggle flipping back to equal ack_tgl before acceptance means no request.
- Reset mid-RUN aborts immediately to reset values; software detects this as ack = 0.
- Index wrap: i never exceeds len - 1; addresses >= DEPTH are never read.

Decomposition:
- Shared package nn_pio_pkg:
  - opcode localparams
  - command/response field bit positions
  - FSM state enum
  - Q8.8 constants (QMAX = 16'h7FFF, QMIN = 16'h8000)
- Sub-module nn_mac_unit: signed multiply, accumulate with clear/enable, shift/ReLU/saturate output, sat flag.
- The top level holds the handshake, register files and FSM.

Test Plan:
- Reset, then hps_cmd = 0 -> fpga_rsp = 0x00000000, busy = 0, no ack toggle.
- LD_W idx 0 = 0x0180, LD_X idx 0 = 0x0200, LD_W idx 1 = 0xFF00, LD_X idx 1 = 0x0080, then RUN len 2 -> ack after 5 cycles, data = 0x0280 (2.5), sat = 0, result_valid = 1.
- Same operands with w0 = 0xFE00 (-2.0), RUN len 2, ReLU = 1 -> data = 0x0000, sat = 0. Same with ReLU = 0 -> data = 0xFB80 (-4.5).
- All 16 entries w = x = 0x7F00, RUN len 16 -> data = 0x7FFF, sat = 1. Follow with RD -> same data, ack toggles after 2 cycles.
- Errors:
  - LD_W idx 0 = 0x1234, then LD_W idx 15 = 0x0100 -> second succeeds, err = 0.
  - Opcode 7 -> err = 1, ack toggles.
  - RUN len 0 and RUN len 17 -> err = 1, storage unchanged.
- Toggle a RUN len 16, flip the toggle for LD_X during MAC, and assert reset_reset_n = 0 mid-MAC in a separate run:
  - The queued LD_X is accepted right after the RUN ack.
  - The reset run returns fpga_rsp = 0, busy = 0 asynchronously.
